// File: rtl/alu_arbiter_ctrl.sv
// rtl/alu_arbiter_ctrl.sv - round-robin sharing of one registered-output ALU between two requesters
module alu_arbiter_ctrl #(
  parameter int              DATA_W   = 16,
  parameter logic [DATA_W-1:0] DIV0_VAL = {DATA_W{1'b1}},
  parameter logic [3:0]      NOP_FUN  = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_fun,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_fun,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_fun,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_arith,
  input  logic              alu_logic,
  input  logic              alu_cmp,
  input  logic              alu_shift,
  output logic              busy
);

  localparam logic [3:0] DIV_FUN = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [3:0]          fun_q;
  logic                id_q;
  logic                last_grant_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [3:0]          rsp_flags_q;
  logic                rsp_err_q;

  logic                grant0;
  logic                grant1;
  logic                div0;

  // On a tie the requester that did not win last time gets the ALU.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  assign div0 = (fun_q == DIV_FUN) && (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      fun_q        <= NOP_FUN;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q          <= grant1 ? req1_a   : req0_a;
            b_q          <= grant1 ? req1_b   : req0_b;
            fun_q        <= grant1 ? req1_fun : req0_fun;
            id_q         <= grant1;
            last_grant_q <= grant1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // Divide-by-zero never waits for the ALU result; the answer is fixed.
          if (div0) begin
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= DIV0_VAL;
            rsp_flags_q <= 4'b1000;
            fun_q       <= NOP_FUN;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            rsp_flags_q <= {alu_arith, alu_logic, alu_cmp, alu_shift};
            state_q     <= CAPT;
          end
        end
        CAPT: begin
          rsp_data_q  <= alu_out;
          fun_q       <= NOP_FUN;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fun   = fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb/tb_alu_arbiter_ctrl.sv - scoreboard bench for alu_arbiter_ctrl with a behavioural ALU
module tb_alu_arbiter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic [3:0]  req0_fun;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  req1_fun;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_fun;
  logic        alu_arith, alu_logic, alu_cmp, alu_shift;
  logic        busy;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  alu_arbiter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_arith(alu_arith), .alu_logic(alu_logic), .alu_cmp(alu_cmp),
    .alu_shift(alu_shift), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU_16bit: registered result, combinational class flags.
  function automatic logic [15:0] alu_calc(input logic [15:0] a, b, input logic [3:0] f);
    case (f)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return 16'(a * b);
      4'b0011: return (b != 16'd0) ? a / b : 16'd0;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return ~(a & b);
      4'b0111: return ~(a | b);
      4'b1000: return a ^ b;
      4'b1001: return ~(a ^ b);
      4'b1010: return {15'd0, a == b};
      4'b1011: return {15'd0, a > b};
      4'b1100: return {15'd0, a < b};
      4'b1101: return a >> 1;
      4'b1110: return a << 1;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_calc(alu_a, alu_b, alu_fun);
  assign alu_arith = (alu_fun <= 4'd3);
  assign alu_logic = (alu_fun >= 4'd4) && (alu_fun <= 4'd9);
  assign alu_cmp   = (alu_fun >= 4'd10) && (alu_fun <= 4'd12);
  assign alu_shift = (alu_fun == 4'd13) || (alu_fun == 4'd14);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        fail_to("unexpected response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",    32'(rsp_id),    32'(e.id));
        chk("rsp_data",  32'(rsp_data),  32'(e.data));
        chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        chk("rsp_err",   32'(rsp_err),   32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [15:0] a, b, input logic [3:0] f);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_fun = f;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_fun = f;
    end
  endtask

  task automatic wait_grant(input bit id, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_wait(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_to({nm, " idle"});
    tick();
  endtask

  // Single operation with rsp_ready high; checks response latency and busy span.
  task automatic do_op(input bit id, input logic [15:0] a, b, input logic [3:0] f,
                       input logic [15:0] ed, input logic [3:0] ef, input bit ee,
                       input int lat, input string nm);
    bit got;
    int first;
    int busy_n;
    drive_req(id, 1'b1, a, b, f);
    wait_grant(id, got);
    if (!got) begin
      fail_to({nm, " grant"});
      drive_req(id, 1'b0, a, b, f);
      return;
    end
    chk({nm, " other ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
    sb.push_back('{id: id, data: ed, flags: ef, err: ee});
    tick();
    drive_req(id, 1'b0, 16'h0, 16'h0, 4'h0);
    first = 0;
    busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid && first == 0) first = k;
      if (busy) busy_n++;
      else break;
    end
    chk({nm, " latency"}, 32'(first), 32'(lat));
    chk({nm, " busy cycles"}, 32'(busy_n), 32'(lat));
    idle_wait(nm);
  endtask

  // Both requesters held valid; grants must alternate starting with requester 0.
  task automatic tie(input logic [15:0] a0, b0, input logic [3:0] f0, input logic [15:0] d0, input logic [3:0] g0,
                     input logic [15:0] a1, b1, input logic [3:0] f1, input logic [15:0] d1, input logic [3:0] g1,
                     input int n, input string nm);
    bit exp_id;
    bit got;
    exp_id = 1'b0;
    drive_req(1'b0, 1'b1, a0, b0, f0);
    drive_req(1'b1, 1'b1, a1, b1, f1);
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        fail_to({nm, " grant"});
        break;
      end
      chk({nm, " grant id"}, 32'(req1_ready), 32'(exp_id));
      chk({nm, " single grant"}, 32'(req0_ready & req1_ready), 32'd0);
      sb.push_back('{id: exp_id, data: exp_id ? d1 : d0, flags: exp_id ? g1 : g0, err: 1'b0});
      tick();
      exp_id = ~exp_id;
    end
    drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
    idle_wait(nm);
  endtask

  initial begin
    bit got;
    int cnt;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_id",    32'(rsp_id),    32'd0);
    chk("reset rsp_data",  32'(rsp_data),  32'd0);
    chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    chk("reset alu_a",     32'(alu_a),     32'd0);
    chk("reset alu_b",     32'(alu_b),     32'd0);
    chk("reset alu_fun",   32'(alu_fun),   32'hF);
    chk("reset busy",      32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    tie(16'hF0F0, 16'h0FF0, 4'b0100, 16'h00F0, 4'b0100,
        16'h0005, 16'h0003, 4'b1011, 16'h0001, 4'b0010, 3, "tie");

    do_op(1'b0, 16'h0003, 16'h0004, 4'b0000, 16'h0007, 4'b1000, 1'b0, 3, "add");

    // Backpressure: response held while requester 1 waits with changing inputs.
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 16'h8001, 16'h0000, 4'b1110);
    wait_grant(1'b0, got);
    if (!got) fail_to("bp grant");
    sb.push_back('{id: 1'b0, data: 16'h0002, flags: 4'b0001, err: 1'b0});
    tick();
    drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_to("bp rsp_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_req(1'b1, 1'b1, 16'hDEA0 + 16'(i), 16'h1230 + 16'(i), 4'(i));
      @(negedge clk);
      chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
      chk("bp rsp_data held",  32'(rsp_data),  32'h0002);
      chk("bp rsp_flags held", 32'(rsp_flags), 32'h1);
      chk("bp req1_ready low", 32'(req1_ready), 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    drive_req(1'b1, 1'b1, 16'h0001, 16'h0001, 4'b0000);
    @(negedge clk);
    chk("bp req1_ready at handshake", 32'(req1_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("bp req1_ready after handshake", 32'(req1_ready), 32'd1);
    sb.push_back('{id: 1'b1, data: 16'h0002, flags: 4'b1000, err: 1'b0});
    tick();
    drive_req(1'b1, 1'b0, 16'h0, 16'h0, 4'h0);
    idle_wait("bp");

    do_op(1'b0, 16'h0010, 16'h0000, 4'b0011, 16'hFFFF, 4'b1000, 1'b1, 2, "div0");
    do_op(1'b0, 16'h0010, 16'h0004, 4'b0011, 16'h0004, 4'b1000, 1'b0, 3, "div");
    do_op(1'b1, 16'h1234, 16'h5678, 4'b1111, 16'h0000, 4'b0000, 1'b0, 3, "nop");
    do_op(1'b1, 16'hFFFF, 16'h0002, 4'b0000, 16'h0001, 4'b1000, 1'b0, 3, "add wrap");

    // Reset during CAPT abandons the operation.
    drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 4'b0000);
    wait_grant(1'b0, got);
    if (!got) fail_to("rst grant");
    tick();
    drive_req(1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    tick();
    chk("rst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data",  32'(rsp_data),  32'd0);
    chk("rst rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst alu_fun",   32'(alu_fun),   32'hF);
    chk("rst alu_a",     32'(alu_a),     32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("rst no response", 32'(cnt), 32'd0);
    tick();
    tie(16'h0001, 16'h0002, 4'b0000, 16'h0003, 4'b1000,
        16'h0009, 16'h0004, 4'b0001, 16'h0005, 4'b1000, 2, "tie after reset");

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Shares one ALU_16bit instance between two requesters. The block arbitrates round-robin, latches the winning request and sequences the ALU's one-cycle registered result latency. It captures the result and the class flags, then returns them on a single response channel tagged with the requester ID. It sits between the two client blocks and the ALU, and is the only driver of the ALU's A, B and ALU_FUN inputs.

Parameters:
DATA_W, 16, operand and result width; must match the ALU.
DIV0_VAL, 16'hFFFF, result returned for divide-by-zero.
NOP_FUN, 4'b1111, ALU_FUN driven while no operation is in flight.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_a, req0_b  in  DATA_W  requester 0 operands
req0_fun  in  4  requester 0 ALU function code
req1_valid, req1_ready, req1_a, req1_b, req1_fun  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes the response
rsp_id  out  1  requester that owns the response
rsp_data  out  DATA_W  result
rsp_flags  out  4  {arith, logic, cmp, shift} class flags
rsp_err  out  1  divide-by-zero occurred
alu_a, alu_b  out  DATA_W  to ALU A and B
alu_fun  out  4  to ALU ALU_FUN
alu_out  in  DATA_W  from ALU ALU_OUT (registered in the ALU)
alu_arith, alu_logic, alu_cmp, alu_shift  in  1  from the ALU flags (combinational on ALU_FUN)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid, rsp_id, rsp_data, rsp_flags and rsp_err are all 0.
  - Operand registers are 0 and the function register is NOP_FUN.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation abandons the operation; no response is produced.
- alu_a, alu_b and alu_fun are driven directly from the internal operand and function registers, so they are stable for a full cycle.
- FSM states are IDLE, ISSUE, CAPT and RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grantN, combinational.
  - Grant when only one requester is valid: that requester.
  - Grant when both are valid: the requester that is not last_grant.
  - On acceptance: latch a, b, fun and id, update last_grant, go to ISSUE.
  - A requester is never accepted in any state other than IDLE.
- ISSUE (1 cycle):
  - The ALU sees the latched operands; the ALU registers its result at the end of this cycle.
  - Flags are sampled into the flag register at the end of ISSUE.
  - Divide-by-zero (fun==4'b0011 and b==0): set err, load rsp_data=DIV0_VAL, force flags to 4'b1000, then go directly to RESP (CAPT is skipped).
  - Otherwise go to CAPT.
- CAPT (1 cycle):
  - rsp_data <= alu_out.
  - Function register <= NOP_FUN.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_flags and rsp_err are held stable.
  - On rsp_valid & rsp_ready: clear rsp_valid and rsp_err, go to IDLE.
  - A new request can be accepted in the cycle after the handshake at the earliest.
- Latency:
  - Normal operation: accept edge T0 → rsp_valid high in cycle T0+3 (ISSUE, CAPT, RESP).
  - Divide-by-zero: rsp_valid high in cycle T0+2.
  - Maximum throughput is one operation per 4 cycles when rsp_ready is held high.
- Function 4'b1111: passed through to the ALU; the result is 0 and the flags are 0. It is not an error.
- Arithmetic results are truncated to DATA_W exactly as the ALU does; the controller never widens or extends them.
- A requester may change its inputs freely while its ready is low. Its values are sampled only in the acceptance cycle.

Test Plan:
- Single request, add: req0 a=16'h0003, b=16'h0004, fun=0000 with rsp_ready=1 → req0_ready pulses at T0; rsp_valid in cycle T0+3 with rsp_data=16'h0007, rsp_flags=4'b1000, rsp_id=0, rsp_err=0.
- Tie arbitration: both requesters hold valid for 3 operations (req0 AND 16'hF0F0 & 16'h0FF0; req1 A>B with 5 and 3) → grant order 0,1,0; responses 16'h00F0 with flags 0100, then 16'h0001 with flags 0010, ids matching.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises (a=16'h8001, fun=1110) → rsp_data=16'h0002 and flags 0001 held stable; req1_valid=1 meanwhile but req1_ready stays 0 until after the handshake.
- Divide-by-zero: a=16'h0010, b=0, fun=0011 → rsp_valid at T0+2 with rsp_data=16'hFFFF, rsp_err=1, flags 1000; a following 16'h0010/16'h0004 divide returns 16'h0004 with err=0.
- Reset mid-operation: assert rst_n=0 during CAPT → all outputs reset immediately (asynchronously); no response after release; the next tie is granted to requester 0.
- NOP function: fun=1111 → rsp_data=0, rsp_flags=0, rsp_err=0; busy high for exactly 3 cycles plus the cycles spent waiting on rsp_ready.
